updown_jk_count: RTL and testbench
==================================

UPDOWN_JK_COUNT -- requirements
Module: updown_jk_count

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port sclr, input, 1 bit: synchronous clear to zero.
REQ-005 The module SHALL have port load, input, 1 bit: synchronous parallel load of d.
REQ-006 The module SHALL have port d, input, WIDTH bits: load value.
REQ-007 The module SHALL have port en, input, 1 bit: count enable.
REQ-008 The module SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-009 The module SHALL have port sat, input, 1 bit: 1 = saturate at the terminal value, 0 = wrap around.
REQ-010 The module SHALL have port q, output, WIDTH bits: current count.
REQ-011 The module SHALL have port tc, output, 1 bit: terminal count, combinational from q and dir.
REQ-012 The module SHALL have port ovf, output, 1 bit: registered one-cycle pulse on wrap-around.

Function
REQ-013 The counter SHALL be fully synchronous: every bit is clocked by clk, with no ripple clocking.
REQ-014 Per-edge priority SHALL be sclr > load > en; the count SHALL hold when none of them is asserted.
REQ-015 When sclr=1, q SHALL become 0 and ovf SHALL become 0 at the next edge.
REQ-016 When load=1 and sclr=0, q SHALL become d at the next edge, ovf SHALL become 0, and en is ignored.
REQ-017 When en=1, dir=1 and q is not all-ones, q SHALL become q+1 at the next edge (latency 1 cycle).
REQ-018 When en=1, dir=0 and q is not 0, q SHALL become q-1 at the next edge.
REQ-019 tc SHALL be 1 exactly when (dir=1 and q is all-ones) or (dir=0 and q=0); otherwise tc SHALL be 0.
REQ-020 At terminal count with en=1 and sat=0, q SHALL wrap (all-ones->0 up, 0->all-ones down) and ovf SHALL be 1 for the following cycle only.
REQ-021 At terminal count with en=1 and sat=1, q SHALL hold its value and ovf SHALL stay 0.
REQ-022 ovf SHALL be 0 in every cycle not immediately following a wrap.
REQ-023 A change of dir SHALL take effect at the same edge it is sampled, with no dead cycle.
REQ-024 All arithmetic SHALL be modulo 2^WIDTH, with no carry-out beyond ovf.

Reset
REQ-025 When rst=0, q SHALL be forced to 0 and ovf to 0 immediately, independent of clk.
REQ-026 Reset SHALL override sclr, load and en, including during a count or a load.
REQ-027 After rst deasserts, the first state change SHALL occur on the first rising clk edge that sees rst=1.

Structure
REQ-028 Each counter bit SHALL be one instance of sub-module jk_cell: a JK flip-flop with an asynchronous active-low reset and a J/K truth table of hold/reset/set/toggle.
REQ-029 The count logic SHALL drive each cell's J and K: J=K=toggle for counting, and J=d[i], K=~d[i] for a load or (J=0, K=1) for sclr.
REQ-030 Toggle SHALL be a carry chain: bit i toggles when all lower bits are 1 (up) or all 0 (down).
REQ-031 Shared package counter_pkg SHALL hold the direction encodings DIR_UP=1 and DIR_DN=0; no other shared types are required.

Verification (WIDTH=4)
REQ-032 The bench SHALL apply rst=0 mid-count at q=9 without a clock edge and check q=0 and ovf=0 immediately, then release rst with en=1, dir=1 and check q=1 after one edge.
REQ-033 The bench SHALL set en=1, dir=1, sat=0 from q=14 for three edges and check q=15 (tc=1), q=0 (ovf=1), then q=1 (ovf=0).
REQ-034 The bench SHALL set en=1, dir=0, sat=1 from q=1 for three edges and check q=0 (tc=1), q=0, q=0, with ovf remaining 0.
REQ-035 The bench SHALL assert load=1, d=11 and en=1 together with sclr=0, then sclr=1 and load=1 together, and check q=11 after the first edge and q=0 after the second.
REQ-036 The bench SHALL count up from q=7 (dir=1), toggle dir to 0 on the next cycle, and check q=8 then q=7.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down JK counter.
// Direction values match the dir input pin: 1 counts up, 0 counts down.
package counter_pkg;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;
endpackage : counter_pkg

// File: rtl/updown_jk_count_jk_cell.sv
// One counter bit: JK flip-flop with asynchronous active-low reset.
// J/K behaviour: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case ({j, k})
         2'b00:   q_d = q_q;
         2'b01:   q_d = 1'b0;
         2'b10:   q_d = 1'b1;
         default: q_d = ~q_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q_q <= 1'b0;
      else      q_q <= q_d;
   end

   assign q = q_q;

endmodule : jk_cell

// File: rtl/updown_jk_count.sv
// Synchronous up/down counter built from JK cells, with clear, load,
// saturate-or-wrap at the terminal value and a registered overflow pulse.
module updown_jk_count
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             dir,
   input  logic             sat,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] up_carry;
   logic [WIDTH-1:0] dn_carry;
   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] j_in;
   logic [WIDTH-1:0] k_in;
   logic             step_ok;
   logic             ovf_q;
   logic             ovf_d;

   assign tc = (dir == DIR_UP) ? (&cnt) : ~(|cnt);

   // Saturating at the terminal value simply suppresses every toggle.
   assign step_ok = en & ~(tc & sat);

   assign up_carry[0] = 1'b1;
   assign dn_carry[0] = 1'b1;

   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
         assign up_carry[gi] = up_carry[gi-1] &  cnt[gi-1];
         assign dn_carry[gi] = dn_carry[gi-1] & ~cnt[gi-1];
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign toggle[gi] = step_ok & ((dir == DIR_UP) ? up_carry[gi] : dn_carry[gi]);

         always_comb begin
            j_in[gi] = toggle[gi];
            k_in[gi] = toggle[gi];
            if (sclr) begin
               j_in[gi] = 1'b0;
               k_in[gi] = 1'b1;
            end else if (load) begin
               j_in[gi] = d[gi];
               k_in[gi] = ~d[gi];
            end
         end

         jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_in[gi]),
            .k   (k_in[gi]),
            .q   (cnt[gi])
         );
      end
   endgenerate

   // A wrap is a counting step taken from the terminal value without saturation.
   always_comb begin
      ovf_d = ~sclr & ~load & en & tc & ~sat;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ovf_q <= 1'b0;
      else      ovf_q <= ovf_d;
   end

   assign q   = cnt;
   assign ovf = ovf_q;

endmodule : updown_jk_count

// File: tb/tb_updown_jk_count.sv
// Scoreboard bench for updown_jk_count (WIDTH=4): stimulus pushes expected
// {q,tc,ovf} tagged with the edge it applies to; a monitor pops and compares.
module tb_updown_jk_count;
   import counter_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sclr = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] d = '0;
   logic         en = 1'b0;
   logic         dir = DIR_DN;
   logic         sat = 1'b0;
   logic [W-1:0] q;
   logic         tc;
   logic         ovf;

   typedef struct {
      int           cyc;
      logic [W-1:0] q;
      logic         tc;
      logic         ovf;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   done = 1'b0;

   updown_jk_count #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .sclr (sclr),
      .load (load),
      .d    (d),
      .en   (en),
      .dir  (dir),
      .sat  (sat),
      .q    (q),
      .tc   (tc),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [W-1:0] aq, input logic atc,
                                 input logic aovf, input logic [W-1:0] eq, input logic etc,
                                 input logic eovf);
      n_checks++;
      if (aq !== eq || atc !== etc || aovf !== eovf) begin
         n_fail++;
         $display("FAIL %s: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%b ovf=%b",
                  name, aq, atc, aovf, eq, etc, eovf);
      end else begin
         $display("ok   %s: q=%0d tc=%b ovf=%b", name, aq, atc, aovf);
      end
   endfunction

   // Drive one edge's inputs in the low phase and queue the expected post-edge state.
   task automatic step(input string name, input logic s, input logic l, input logic [W-1:0] dv,
                       input logic e, input logic di, input logic sa,
                       input logic [W-1:0] eq, input logic etc, input logic eovf);
      exp_t x;
      @(negedge clk);
      sclr = s; load = l; d = dv; en = e; dir = di; sat = sa;
      x.cyc = cyc + 1; x.q = eq; x.tc = etc; x.ovf = eovf; x.name = name;
      sb.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            if (x.cyc != cyc) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s: checked at edge %0d, required edge %0d", x.name, cyc, x.cyc);
            end else begin
               check(x.name, q, tc, ovf, x.q, x.tc, x.ovf);
            end
         end
      end
   end

   initial begin : stimulus
      exp_t x;
      #1;
      check("reset_state", q, tc, ovf, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Async reset mid-count at q=9, then count resumes from 0.
      step("load8",      0, 1, 4'd8,  0, DIR_UP, 0, 4'd8,  0, 0);
      step("cnt_to9",    0, 0, 4'd0,  1, DIR_UP, 0, 4'd9,  0, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("async_rst", q, 1'b0, ovf, 4'd0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      x.cyc = cyc + 1; x.q = 4'd1; x.tc = 1'b0; x.ovf = 1'b0; x.name = "post_rst_cnt";
      sb.push_back(x);

      // Wrap up from 14.
      step("load14",     0, 1, 4'd14, 0, DIR_UP, 0, 4'd14, 0, 0);
      step("up_15",      0, 0, 4'd0,  1, DIR_UP, 0, 4'd15, 1, 0);
      step("up_wrap0",   0, 0, 4'd0,  1, DIR_UP, 0, 4'd0,  0, 1);
      step("up_1",       0, 0, 4'd0,  1, DIR_UP, 0, 4'd1,  0, 0);

      // Saturate down at 0.
      step("load1",      0, 1, 4'd1,  0, DIR_DN, 1, 4'd1,  0, 0);
      step("dn_sat_a",   0, 0, 4'd0,  1, DIR_DN, 1, 4'd0,  1, 0);
      step("dn_sat_b",   0, 0, 4'd0,  1, DIR_DN, 1, 4'd0,  1, 0);
      step("dn_sat_c",   0, 0, 4'd0,  1, DIR_DN, 1, 4'd0,  1, 0);

      // Wrap down from 0, then a load directly after the wrap clears ovf.
      step("dn_wrap15",  0, 0, 4'd0,  1, DIR_DN, 0, 4'd15, 0, 1);
      step("dn_14",      0, 0, 4'd0,  1, DIR_DN, 0, 4'd14, 0, 0);
      step("dn_wrap_a",  0, 1, 4'd0,  0, DIR_DN, 0, 4'd0,  1, 0);
      step("dn_wrap_b",  0, 0, 4'd0,  1, DIR_DN, 0, 4'd15, 0, 1);
      step("load_clr_o", 0, 1, 4'd5,  1, DIR_DN, 0, 4'd5,  0, 0);

      // Saturate up at 15.
      step("load15",     0, 1, 4'd15, 0, DIR_UP, 1, 4'd15, 1, 0);
      step("up_sat",     0, 0, 4'd0,  1, DIR_UP, 1, 4'd15, 1, 0);

      // Priority: load over en, sclr over load.
      step("load_over_en", 0, 1, 4'd11, 1, DIR_UP, 0, 4'd11, 0, 0);
      step("sclr_over_ld", 1, 1, 4'd11, 1, DIR_UP, 0, 4'd0,  0, 0);

      // Direction change takes effect at the sampled edge.
      step("load7",      0, 1, 4'd7,  0, DIR_UP, 0, 4'd7,  0, 0);
      step("up_8",       0, 0, 4'd0,  1, DIR_UP, 0, 4'd8,  0, 0);
      step("dn_7",       0, 0, 4'd0,  1, DIR_DN, 0, 4'd7,  0, 0);
      step("hold_7",     0, 0, 4'd0,  0, DIR_DN, 0, 4'd7,  0, 0);
      step("up_mid",     0, 0, 4'd0,  1, DIR_UP, 0, 4'd8,  0, 0);

      repeat (3) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left in scoreboard, required 0", sb.size());
      end
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #20000;
      if (!done) begin
         $display("FAIL timeout: bench did not complete, required completion within 20000 time units");
         $fatal(1, "timeout");
      end
   end

endmodule : tb_updown_jk_count
